// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: state encoding and sizing constants.
package mem_responder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int unsigned LATENCY_DEFAULT = 2;
  localparam int unsigned WORD_BYTES      = 4;
  localparam int unsigned DATA_WIDTH      = WORD_BYTES * 8;
  localparam int unsigned CNT_WIDTH       = 4;

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised RAM built from independent byte lanes, one write port and a
// registered read port.
module byte_lane_ram
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [WORD_BYTES-1:0] we_i,
  input  logic                  re_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [7:0]            mem_q [WORD_BYTES][DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Per-lane write; contents are never cleared by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(WORD_BYTES); i++) begin
      if (we_i[i]) mem_q[i][addr_i] <= wdata_i[8*i +: 8];
    end
  end

  // Registered read; the output register is the only reset state here.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
        rdata_q[8*i +: 8] <= mem_q[i][addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: latches a CPU request, holds MemBusy for
// LATENCY cycles, then commits the write or loads the read word.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  input  logic [3:0]  WriteEnable,
  input  logic        ReadEnable,
  output logic [31:0] DataOut,
  output logic        MemBusy
);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [WORD_BYTES-1:0] we_q, we_d;
  logic                  is_write_q, is_write_d;
  logic                  busy_q, busy_d;

  logic                  req_c;
  logic                  access_c;
  logic [WORD_BYTES-1:0] ram_we_c;
  logic                  ram_re_c;
  logic                  unused_addr_c;

  assign req_c         = ReadEnable | (|WriteEnable);
  assign unused_addr_c = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

  // Next-state logic: accept in IDLE, count down in BUSY, finish at cnt==0.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    we_d       = we_q;
    is_write_d = is_write_q;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          idx_d      = Address[ADDR_WIDTH+1:2];
          data_d     = DataIn;
          we_d       = WriteEnable;
          is_write_d = |WriteEnable;
          cnt_d      = CNT_WIDTH'(LATENCY - 1);
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_WIDTH'(1);
        else             state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_BUSY);
  end

  // The access lands on the final BUSY edge; a coincident reset suppresses it.
  assign access_c = (state_q == ST_BUSY) && (cnt_q == '0) && !rst;
  assign ram_we_c = (access_c && is_write_q) ? we_q : '0;
  assign ram_re_c = access_c && !is_write_q;

  // State, counter and request latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      we_q       <= '0;
      is_write_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      we_q       <= we_d;
      is_write_q <= is_write_d;
      busy_q     <= busy_d;
    end
  end

  byte_lane_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .addr_i (idx_q),
    .wdata_i(data_q),
    .we_i   (ram_we_c),
    .re_i   (ram_re_c),
    .rdata_o(DataOut)
  );

  assign MemBusy = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at LATENCY 2 (main), 1 and 4 (handshake).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic [31:0] addr  [3];
  logic [31:0] din   [3];
  logic [3:0]  wen   [3];
  logic        ren   [3];
  logic [31:0] dout  [3];
  logic        busy  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst[0]), .Address(addr[0]), .DataIn(din[0]),
    .WriteEnable(wen[0]), .ReadEnable(ren[0]), .DataOut(dout[0]), .MemBusy(busy[0]));

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .Address(addr[1]), .DataIn(din[1]),
    .WriteEnable(wen[1]), .ReadEnable(ren[1]), .DataOut(dout[1]), .MemBusy(busy[1]));

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) u_dut2 (
    .clk(clk), .rst(rst[2]), .Address(addr[2]), .DataIn(din[2]),
    .WriteEnable(wen[2]), .ReadEnable(ren[2]), .DataOut(dout[2]), .MemBusy(busy[2]));

  // Controller model: hold request until MemBusy=1, drop it, wait for MemBusy=0.
  task automatic do_access(input int k, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] we, input logic re,
                           output int width, output logic [31:0] rdata, output bit ok);
    addr[k] = a; din[k] = d; wen[k] = we; ren[k] = re;
    ok = 1'b0; width = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (busy[k]) ok = 1'b1;
    end
    wen[k] = 4'b0; ren[k] = 1'b0;
    if (ok) begin
      width = 1;
      for (int i = 0; i < 40 && busy[k]; i++) begin
        @(posedge clk); #1;
        if (busy[k]) width++;
      end
    end
    rdata = dout[k];
  endtask

  task automatic test_reset;
    rst[0] = 1'b1; ren[0] = 1'b1; addr[0] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy[0] !== 1'b0) begin
        errors++; $display("FAIL reset_busy cyc%0d got %b want 0", i, busy[0]);
      end
      checks++;
      if (dout[0] !== 32'h0) begin
        errors++; $display("FAIL reset_dout cyc%0d got %h want 0", i, dout[0]);
      end
    end
    rst[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++; $display("FAIL reset_release_busy got %b want 1", busy[0]);
    end
    ren[0] = 1'b0;
    for (int i = 0; i < 10 && busy[0]; i++) begin @(posedge clk); #1; end
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++; $display("FAIL reset_drain_busy got %b want 0", busy[0]);
    end
  endtask

  task automatic test_full_word;
    int w; logic [31:0] r; bit ok;
    do_access(0, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, w, r, ok);
    checks++;
    if (!ok || w != 2) begin
      errors++; $display("FAIL full_write_busy ok=%0d width=%0d want 2", ok, w);
    end
    do_access(0, 32'h10, 32'h0, 4'b0000, 1'b1, w, r, ok);
    checks++;
    if (!ok || w != 2) begin
      errors++; $display("FAIL full_read_busy ok=%0d width=%0d want 2", ok, w);
    end
    checks++;
    if (r !== 32'hDEADBEEF) begin
      errors++; $display("FAIL full_read_data got %h want deadbeef", r);
    end
  endtask

  task automatic test_byte_lane;
    int w; logic [31:0] r; bit ok;
    do_access(0, 32'h20, 32'h11223344, 4'b1111, 1'b0, w, r, ok);
    do_access(0, 32'h20, 32'hAAAAAAAA, 4'b0100, 1'b0, w, r, ok);
    do_access(0, 32'h20, 32'h0, 4'b0000, 1'b1, w, r, ok);
    checks++;
    if (!ok || r !== 32'h11AA3344) begin
      errors++; $display("FAIL byte_lane got %h want 11aa3344 (ok=%0d)", r, ok);
    end
  endtask

  task automatic test_priority_alias;
    int w; logic [31:0] r; bit ok;
    do_access(0, 32'h30, 32'h12345678, 4'b1111, 1'b0, w, r, ok);
    do_access(0, 32'h30, 32'h0, 4'b0000, 1'b1, w, r, ok);
    do_access(0, 32'h30, 32'h0000BEEF, 4'b0011, 1'b1, w, r, ok);
    checks++;
    if (!ok || r !== 32'h12345678) begin
      errors++; $display("FAIL priority_dout got %h want 12345678 (ok=%0d)", r, ok);
    end
    do_access(0, 32'h30 + (32'd4 << 10), 32'h0, 4'b0000, 1'b1, w, r, ok);
    checks++;
    if (!ok || r !== 32'h1234BEEF) begin
      errors++; $display("FAIL alias_high got %h want 1234beef (ok=%0d)", r, ok);
    end
    do_access(0, 32'h33, 32'h0, 4'b0000, 1'b1, w, r, ok);
    checks++;
    if (!ok || r !== 32'h1234BEEF) begin
      errors++; $display("FAIL alias_low got %h want 1234beef (ok=%0d)", r, ok);
    end
  endtask

  task automatic test_reset_mid;
    int w; logic [31:0] r; bit ok;
    do_access(0, 32'h40, 32'h00000000, 4'b1111, 1'b0, w, r, ok);
    addr[0] = 32'h40; din[0] = 32'hCAFEF00D; wen[0] = 4'b1111;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (busy[0]) ok = 1'b1;
    end
    wen[0] = 4'b0;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    checks++;
    if (!ok || busy[0] !== 1'b0) begin
      errors++; $display("FAIL midreset_busy got %b want 0 (ok=%0d)", busy[0], ok);
    end
    checks++;
    if (dout[0] !== 32'h0) begin
      errors++; $display("FAIL midreset_dout got %h want 0", dout[0]);
    end
    do_access(0, 32'h40, 32'h0, 4'b0000, 1'b1, w, r, ok);
    checks++;
    if (!ok || r !== 32'h00000000) begin
      errors++; $display("FAIL midreset_mem got %h want 0 (ok=%0d)", r, ok);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_b [4];
    exp_b[0] = 1'b1; exp_b[1] = 1'b1; exp_b[2] = 1'b0; exp_b[3] = 1'b1;
    addr[0] = 32'h10; ren[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy[0] !== exp_b[i]) begin
        errors++; $display("FAIL b2b_busy cyc%0d got %b want %b", i, busy[0], exp_b[i]);
      end
      if (i == 2) begin
        checks++;
        if (dout[0] !== 32'hDEADBEEF) begin
          errors++; $display("FAIL b2b_data got %h want deadbeef", dout[0]);
        end
      end
    end
    ren[0] = 1'b0;
    for (int i = 0; i < 10 && busy[0]; i++) begin @(posedge clk); #1; end
  endtask

  task automatic test_handshake(input int k, input int lat);
    int w; logic [31:0] r; bit ok;
    logic [31:0] exp_d [8];
    rst[k] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst[k] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_d[i] = 32'hA5000000 | (32'(lat) << 16) | (32'(i) * 32'h0101);
      do_access(k, 32'h200 + 32'(4 * i), exp_d[i], 4'b1111, 1'b0, w, r, ok);
      checks++;
      if (!ok || w != lat) begin
        errors++; $display("FAIL hs%0d_wr_width i=%0d got %0d want %0d (ok=%0d)", lat, i, w, lat, ok);
      end
      do_access(k, 32'h200 + 32'(4 * i), 32'h0, 4'b0000, 1'b1, w, r, ok);
      checks++;
      if (!ok || w != lat || r !== exp_d[i]) begin
        errors++; $display("FAIL hs%0d_rd i=%0d got %h/%0d want %h/%0d", lat, i, r, w, exp_d[i], lat);
      end
    end
    for (int i = 0; i < 8; i++) begin
      do_access(k, 32'h200 + 32'(4 * i), 32'h0, 4'b0000, 1'b1, w, r, ok);
      checks++;
      if (!ok || r !== exp_d[i]) begin
        errors++; $display("FAIL hs%0d_reread i=%0d got %h want %h", lat, i, r, exp_d[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy[k] !== 1'b0) begin
        errors++; $display("FAIL hs%0d_idle cyc%0d got %b want 0", lat, i, busy[k]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; addr[k] = '0; din[k] = '0; wen[k] = '0; ren[k] = 1'b0;
    end
    test_reset;
    test_full_word;
    test_byte_lane;
    test_priority_alias;
    test_reset_mid;
    test_back_to_back;
    test_handshake(1, 1);
    test_handshake(2, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
